// File: rtl/mont_ladder_exp_param_pkg.sv
// Shared state encodings, constants and helpers for the parametrised
// Montgomery-ladder modular exponentiator.
package mont_pkg;

    // Upper bounds for the per-instance widths; the helpers below operate on
    // vectors of these sizes and callers zero-extend their operands into them.
    localparam int MAX_BITS     = 4096;
    localparam int MAX_EXP_BITS = 4096;

    // Ladder controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL_A = 3'd1,
        S_MUL_B = 3'd2,
        S_CONV  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Constant 1; sliced to the operand width to form the conversion operand.
    localparam logic [MAX_BITS-1:0] ONE = MAX_BITS'(1);

    // Index of the most-significant set bit of v; returns 0 for v == 0, so the
    // caller must test for a zero exponent separately.
    function automatic int msb_index(input logic [MAX_EXP_BITS-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_EXP_BITS; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mont_ladder_exp_param_mult.sv
// Combinational Montgomery product P = A*B*R^-1 mod N with R = 2^BITS.
// Operands are expected to be reduced (A, B < N) with N odd and N < R.
module montgomery_mult #(
    parameter int BITS = 1024
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    input  logic [BITS-1:0] n_i,
    input  logic [BITS-1:0] n_prime_i,
    output logic [BITS-1:0] p_o
);

    logic [2*BITS-1:0] fullProd;
    logic [BITS-1:0]   mFactor;
    logic [2*BITS-1:0] mTimesN;
    logic [2*BITS:0]   redSum;
    logic [BITS:0]     redQuot;

    // REDC: add the multiple of N that clears the low BITS bits, divide by R,
    // then one conditional subtraction brings the value back below N.
    always_comb begin
        fullProd = {{BITS{1'b0}}, a_i} * {{BITS{1'b0}}, b_i};
        mFactor  = fullProd[BITS-1:0] * n_prime_i;
        mTimesN  = {{BITS{1'b0}}, mFactor} * {{BITS{1'b0}}, n_i};
        redSum   = {1'b0, fullProd} + {1'b0, mTimesN};
        redQuot  = (BITS+1)'(redSum >> BITS);
        if (redQuot >= {1'b0, n_i}) begin
            p_o = BITS'(redQuot - {1'b0, n_i});
        end else begin
            p_o = redQuot[BITS-1:0];
        end
    end

endmodule

// File: rtl/mont_ladder_exp_param.sv
// Montgomery-ladder modular exponentiator: one Montgomery product per cycle,
// optional leading-zero skip and optional conversion out of Montgomery form.
// The step sequence depends only on the processed bit length, never on the
// exponent bit values.
module mont_ladder_exp_param
    import mont_pkg::*;
#(
    parameter int BITS     = 1024,
    parameter int EXP_BITS = 1024,
    parameter bit SKIP_LZ  = 1'b1,
    parameter int CNT_W    = $clog2(EXP_BITS) + 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [BITS-1:0]     base_mont_i,
    input  logic [EXP_BITS-1:0] exponent_i,
    input  logic [BITS-1:0]     n_i,
    input  logic [BITS-1:0]     n_prime_i,
    input  logic [BITS-1:0]     one_mont_i,
    input  logic                from_mont_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [BITS-1:0]     exp_result_o
);

    state_t              state_q, state_d;
    logic [BITS-1:0]     r0_q, r0_d;
    logic [BITS-1:0]     r1_q, r1_d;
    logic [EXP_BITS-1:0] exp_q, exp_d;
    logic [BITS-1:0]     n_q, n_d;
    logic [BITS-1:0]     nPrime_q, nPrime_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic                fromMont_q, fromMont_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BITS-1:0]     result_q, result_d;

    logic [MAX_EXP_BITS-1:0] expWide;
    logic [CNT_W-1:0]        startIdx;
    logic                    zeroLen;
    logic                    expBit;
    logic [BITS-1:0]         opA;
    logic [BITS-1:0]         opB;
    logic [BITS-1:0]         product;

    // Starting bit index and the empty-ladder case, derived from the live
    // exponent input so they are ready at the accepting edge.
    always_comb begin
        expWide                 = '0;
        expWide[EXP_BITS-1:0]   = exponent_i;
        if (SKIP_LZ) begin
            startIdx = CNT_W'(msb_index(expWide));
        end else begin
            startIdx = CNT_W'(EXP_BITS - 1);
        end
        zeroLen = SKIP_LZ && (exponent_i == '0);
    end

    // Operand selection for the single shared multiplier: the squaring step
    // picks the register named by the current bit, and conversion multiplies
    // by plain 1 to strip the R factor.
    always_comb begin
        expBit = 1'(exp_q >> idx_q);
        opA    = (state_q == S_MUL_B && expBit) ? r1_q : r0_q;
        if (state_q == S_MUL_B && !expBit) begin
            opB = r0_q;
        end else if (state_q == S_CONV) begin
            opB = ONE[BITS-1:0];
        end else begin
            opB = r1_q;
        end
    end

    montgomery_mult #(
        .BITS(BITS)
    ) u_mult (
        .a_i      (opA),
        .b_i      (opB),
        .n_i      (n_q),
        .n_prime_i(nPrime_q),
        .p_o      (product)
    );

    // Next-state logic: ladder sequencing, operand capture on acceptance and
    // result capture as R0 is finalised so it is visible alongside done.
    always_comb begin
        state_d    = state_q;
        r0_d       = r0_q;
        r1_d       = r1_q;
        exp_d      = exp_q;
        n_d        = n_q;
        nPrime_d   = nPrime_q;
        idx_d      = idx_q;
        fromMont_d = fromMont_q;
        result_d   = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    r0_d       = one_mont_i;
                    r1_d       = base_mont_i;
                    exp_d      = exponent_i;
                    n_d        = n_i;
                    nPrime_d   = n_prime_i;
                    fromMont_d = from_mont_i;
                    idx_d      = startIdx;
                    if (!zeroLen) begin
                        state_d = S_MUL_A;
                    end else if (from_mont_i) begin
                        state_d = S_CONV;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL_A: begin
                if (expBit) begin
                    r0_d = product;
                end else begin
                    r1_d = product;
                end
                state_d = S_MUL_B;
            end
            S_MUL_B: begin
                if (expBit) begin
                    r1_d = product;
                end else begin
                    r0_d = product;
                end
                if (idx_q == '0) begin
                    state_d = fromMont_q ? S_CONV : S_DONE;
                end else begin
                    idx_d   = idx_q - CNT_W'(1);
                    state_d = S_MUL_A;
                end
            end
            S_CONV: begin
                r0_d    = product;
                state_d = S_DONE;
            end
            S_DONE: begin
                result_d = r0_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE && state_q != S_DONE) begin
            result_d = r0_d;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            r0_q       <= '0;
            r1_q       <= '0;
            exp_q      <= '0;
            n_q        <= '0;
            nPrime_q   <= '0;
            idx_q      <= '0;
            fromMont_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            exp_q      <= exp_d;
            n_q        <= n_d;
            nPrime_q   <= nPrime_d;
            idx_q      <= idx_d;
            fromMont_q <= fromMont_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign exp_result_o = result_q;

endmodule
